conv3x3_mac_rgb888: RTL

CONV3X3_MAC_RGB888 -- requirements
Module: conv3x3_mac_rgb888

---
 rtl/conv_pkg.sv | 28 ++
 rtl/conv_mac_lane.sv | 68 ++++++
 rtl/conv3x3_mac_rgb888.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 RGB888 convolution MAC.
// State encoding, channel slices and default widths.
package conv_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_NORM  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  localparam int DATA_W_D = 24;
  localparam int COEF_W_D = 8;
  localparam int ACC_W_D  = 20;
  localparam int SHIFT_D  = 4;
  localparam int ADDR_W_D = 17;
  localparam int DEPTH_D  = 130560;

  localparam int TAPS     = 9;
  localparam int LAST_TAP = 8;
  localparam int NCH      = 3;

  localparam int CH_W     = 8;
  localparam int CH_B_LSB = 0;
  localparam int CH_G_LSB = 8;
  localparam int CH_R_LSB = 16;

endpackage

// File: rtl/conv_mac_lane.sv
// One colour channel: signed multiply-accumulate over the taps,
// then arithmetic shift and clamp to an unsigned 8-bit result.
module conv_mac_lane
  import conv_pkg::*;
#(
  parameter int COEF_W = COEF_W_D,
  parameter int ACC_W  = ACC_W_D,
  parameter int SHIFT  = SHIFT_D
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iEn,
  input  logic                     iClr,
  input  logic                     iAcc,
  input  logic                     iNorm,
  input  logic [CH_W-1:0]          iPix,
  input  logic signed [COEF_W-1:0] iCoef,
  output logic [CH_W-1:0]          oRes
);

  localparam int PW = COEF_W + CH_W + 1;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_x;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sh;
  logic [CH_W-1:0]         res_q, res_d;

  assign prod   = $signed({1'b0, iPix}) * iCoef;
  assign prod_x = {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign sh     = acc_q >>> SHIFT;

  // Next accumulator value: clear on accept, add one tap per MAC cycle.
  always_comb begin
    acc_d = acc_q;
    if (iClr)
      acc_d = '0;
    else if (iAcc)
      acc_d = acc_q + prod_x;
  end

  // Floor-shifted accumulator clamped to the 0..255 range.
  always_comb begin
    res_d = res_q;
    if (iNorm) begin
      if (sh[ACC_W-1])
        res_d = '0;
      else if (|sh[ACC_W-2:CH_W])
        res_d = '1;
      else
        res_d = sh[CH_W-1:0];
    end
  end

  // Accumulator and result registers; frozen while iEn is low.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      acc_q <= '0;
      res_q <= '0;
    end else if (iEn) begin
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign oRes = res_q;

endmodule

// File: rtl/conv3x3_mac_rgb888.sv
// 3x3 RGB888 convolution: latches a window, runs 9 serial MAC
// taps per channel, normalises, and writes one pixel to BRAM.
module conv3x3_mac_rgb888
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int COEF_W = COEF_W_D,
  parameter int ACC_W  = ACC_W_D,
  parameter int SHIFT  = SHIFT_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int DEPTH  = DEPTH_D
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iEn,
  input  logic                     iValid,
  input  logic [DATA_W-1:0]        iPix0,
  input  logic [DATA_W-1:0]        iPix1,
  input  logic [DATA_W-1:0]        iPix2,
  input  logic [DATA_W-1:0]        iPix3,
  input  logic [DATA_W-1:0]        iPix4,
  input  logic [DATA_W-1:0]        iPix5,
  input  logic [DATA_W-1:0]        iPix6,
  input  logic [DATA_W-1:0]        iPix7,
  input  logic [DATA_W-1:0]        iPix8,
  input  logic [9*COEF_W-1:0]      iCoef,
  output logic                     oBusy,
  output logic                     oValid,
  output logic                     oWe,
  output logic [DATA_W-1:0]        oPixel,
  output logic [ADDR_W-1:0]        oAddr,
  output logic                     oDone
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e              state_q;
  logic [3:0]          tap_q;
  logic [DATA_W-1:0]   pix_q [TAPS];
  logic [9*COEF_W-1:0] coef_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                valid_q;
  logic                done_q;
  logic [DATA_W-1:0]   pixel_q;
  logic [ADDR_W-1:0]   addr_q;

  logic [DATA_W-1:0]        cur_pix;
  logic signed [COEF_W-1:0] cur_coef;
  logic [CH_W-1:0]          res [NCH];
  logic                     accept;
  logic [DATA_W-1:0]        win [TAPS];

  assign win[0] = iPix0;
  assign win[1] = iPix1;
  assign win[2] = iPix2;
  assign win[3] = iPix3;
  assign win[4] = iPix4;
  assign win[5] = iPix5;
  assign win[6] = iPix6;
  assign win[7] = iPix7;
  assign win[8] = iPix8;

  assign accept = (state_q == S_IDLE) && iValid;

  // Select the pixel and coefficient for the current tap.
  always_comb begin
    cur_pix  = '0;
    cur_coef = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (tap_q == 4'(k)) begin
        cur_pix  = pix_q[k];
        cur_coef = coef_q[k*COEF_W +: COEF_W];
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    conv_mac_lane #(
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W),
      .SHIFT  (SHIFT)
    ) u_lane (
      .iClk   (iClk),
      .iRst   (iRst),
      .iEn    (iEn),
      .iClr   (accept),
      .iAcc   (state_q == S_MAC),
      .iNorm  (state_q == S_NORM),
      .iPix   (cur_pix[g*CH_W +: CH_W]),
      .iCoef  (cur_coef),
      .oRes   (res[g])
    );
  end

  // Control FSM with registered strobes, address and pixel.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q <= S_IDLE;
      tap_q   <= '0;
      coef_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      pixel_q <= '0;
      addr_q  <= '0;
      for (int k = 0; k < TAPS; k++)
        pix_q[k] <= '0;
    end else if (!iEn) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (iValid) begin
            for (int k = 0; k < TAPS; k++)
              pix_q[k] <= win[k];
            coef_q  <= iCoef;
            tap_q   <= '0;
            state_q <= S_MAC;
          end
        end
        S_MAC: begin
          tap_q <= tap_q + 4'd1;
          if (tap_q == 4'(LAST_TAP))
            state_q <= S_NORM;
        end
        S_NORM: begin
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          valid_q <= 1'b1;
          pixel_q <= DATA_W'({res[2], res[1], res[0]});
          addr_q  <= cnt_q;
          done_q  <= (cnt_q == LAST_ADDR);
          cnt_q   <= (cnt_q == LAST_ADDR) ? '0 : cnt_q + 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oBusy  = (state_q != S_IDLE);
  assign oValid = valid_q;
  assign oWe    = valid_q;
  assign oDone  = done_q;
  assign oPixel = pixel_q;
  assign oAddr  = addr_q;

endmodule
